// File: rtl/capture_arb_pkg.sv
// Shared types for the capture arbiter: FSM state encoding and burst-counter sizing.
package capture_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } arb_state_e;

    // Width needed to count 0..max_burst inclusive.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/capture_arb_if.sv
// AXI-Stream bundle used for both arbiter inputs and the shared output.
interface capture_arb_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/capture_arb_stats.sv
// Dual wrapping packet counter, one per arbiter input; only built with CAPTURE_ARB_STATS_EN.
module capture_arb_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_done_0,
    input  logic             pkt_done_1,
    output logic [CNT_W-1:0] pkt_cnt_0,
    output logic [CNT_W-1:0] pkt_cnt_1
);

    // Count completed packets; natural overflow gives the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_0 <= {CNT_W{1'b0}};
            pkt_cnt_1 <= {CNT_W{1'b0}};
        end else begin
            if (pkt_done_0) begin
                pkt_cnt_0 <= pkt_cnt_0 + CNT_W'(1);
            end else begin
                pkt_cnt_0 <= pkt_cnt_0;
            end
            if (pkt_done_1) begin
                pkt_cnt_1 <= pkt_cnt_1 + CNT_W'(1);
            end else begin
                pkt_cnt_1 <= pkt_cnt_1;
            end
        end
    end

endmodule

// File: rtl/capture_arbiter.sv
// Packet-granular two-input AXI-Stream arbiter: forwarded traffic (input 0) has priority,
// capture traffic (input 1) is served at least once per MAX_S0_BURST packets.
// Optional statistics counters are built when CAPTURE_ARB_STATS_EN is defined.
module capture_arbiter
    import capture_arb_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int MAX_S0_BURST         = 4
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    capture_arb_if.slave                  s_axis_0,
    capture_arb_if.slave                  s_axis_1,
    capture_arb_if.master                 m_axis,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_cnt_0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_cnt_1
);

    localparam int                 BURST_W   = burst_cnt_width(MAX_S0_BURST);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_S0_BURST);

    arb_state_e                          state_r;
    arb_state_e                          state_nxt_s;
    logic [BURST_W-1:0]                  burst_cnt_r;
    logic [BURST_W-1:0]                  burst_cnt_nxt_s;
    logic [C_M_AXIS_DATA_WIDTH-1:0]      tdata_s;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]    tstrb_s;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]     tuser_s;
    logic                                tvalid_s;
    logic                                tlast_s;
    logic                                tready_0_s;
    logic                                tready_1_s;

    // State and burst counter registers.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_r     <= IDLE;
            burst_cnt_r <= {BURST_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Arbitration, burst accounting and the combinational output mux.
    always_comb begin
        state_nxt_s     = state_r;
        burst_cnt_nxt_s = burst_cnt_r;
        tdata_s         = {C_M_AXIS_DATA_WIDTH{1'b0}};
        tstrb_s         = {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
        tuser_s         = {C_M_AXIS_TUSER_WIDTH{1'b0}};
        tvalid_s        = 1'b0;
        tlast_s         = 1'b0;
        tready_0_s      = 1'b0;
        tready_1_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_axis_1.tvalid && (!s_axis_0.tvalid || burst_cnt_r == BURST_MAX)) begin
                    state_nxt_s     = PKT1;
                    burst_cnt_nxt_s = {BURST_W{1'b0}};
                end else if (s_axis_0.tvalid) begin
                    state_nxt_s = PKT0;
                    // Only a waiting capture stream consumes burst credit.
                    if (!s_axis_1.tvalid) begin
                        burst_cnt_nxt_s = {BURST_W{1'b0}};
                    end else if (burst_cnt_r == BURST_MAX) begin
                        burst_cnt_nxt_s = burst_cnt_r;
                    end else begin
                        burst_cnt_nxt_s = burst_cnt_r + BURST_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PKT0: begin
                tdata_s    = s_axis_0.tdata;
                tstrb_s    = s_axis_0.tstrb;
                tuser_s    = s_axis_0.tuser;
                tvalid_s   = s_axis_0.tvalid;
                tlast_s    = s_axis_0.tlast;
                tready_0_s = m_axis.tready;
                if (s_axis_0.tvalid && m_axis.tready && s_axis_0.tlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PKT0;
                end
            end
            PKT1: begin
                tdata_s    = s_axis_1.tdata;
                tstrb_s    = s_axis_1.tstrb;
                tuser_s    = s_axis_1.tuser;
                tvalid_s   = s_axis_1.tvalid;
                tlast_s    = s_axis_1.tlast;
                tready_1_s = m_axis.tready;
                if (s_axis_1.tvalid && m_axis.tready && s_axis_1.tlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PKT1;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                burst_cnt_nxt_s = {BURST_W{1'b0}};
            end
        endcase
    end

    assign m_axis.tdata    = tdata_s;
    assign m_axis.tstrb    = tstrb_s;
    assign m_axis.tuser    = tuser_s;
    assign m_axis.tvalid   = tvalid_s;
    assign m_axis.tlast    = tlast_s;
    assign s_axis_0.tready = tready_0_s;
    assign s_axis_1.tready = tready_1_s;

`ifdef CAPTURE_ARB_STATS_EN
    logic pkt_done_0_s;
    logic pkt_done_1_s;

    assign pkt_done_0_s = s_axis_0.tvalid & tready_0_s & s_axis_0.tlast;
    assign pkt_done_1_s = s_axis_1.tvalid & tready_1_s & s_axis_1.tlast;

    capture_arb_stats #(
        .CNT_W (C_S_AXI_DATA_WIDTH)
    ) u_stats (
        .clk        (axi_aclk),
        .rst        (axi_areset),
        .pkt_done_0 (pkt_done_0_s),
        .pkt_done_1 (pkt_done_1_s),
        .pkt_cnt_0  (pkt_cnt_0),
        .pkt_cnt_1  (pkt_cnt_1)
    );
`else
    assign pkt_cnt_0 = {C_S_AXI_DATA_WIDTH{1'b0}};
    assign pkt_cnt_1 = {C_S_AXI_DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_capture_arbiter.sv
// Directed self-checking bench for capture_arbiter; expected counter values follow CAPTURE_ARB_STATS_EN.
module tb_capture_arbiter;

    localparam int DW   = 256;
    localparam int UW   = 128;
    localparam int CW   = 32;
    localparam int MAXB = 4;
`ifdef CAPTURE_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] pkt_cnt_0;
    logic [CW-1:0] pkt_cnt_1;

    always #5 clk = ~clk;

    capture_arb_if #(.DATA_W(DW), .USER_W(UW)) s0_if ();
    capture_arb_if #(.DATA_W(DW), .USER_W(UW)) s1_if ();
    capture_arb_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    capture_arbiter #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXI_DATA_WIDTH   (CW),
        .MAX_S0_BURST         (MAXB)
    ) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s_axis_0   (s0_if),
        .s_axis_1   (s1_if),
        .m_axis     (m_if),
        .pkt_cnt_0  (pkt_cnt_0),
        .pkt_cnt_1  (pkt_cnt_1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source models and output log
    int pkt_left[2], plen[2], beat[2], pid[2], start[2];
    int lcyc;
    bit hs[2];
    bit tog_mode, tog_chk;
    int out_src[$], out_pid[$], out_beat[$], out_cyc[$], ord_src[$];
    int bad_fmt = 0, overlap_bad = 0, idle_bad = 0, mirror_bad = 0;

    task automatic drive_src(input int s);
        logic [DW-1:0]   d;
        logic [UW-1:0]   u;
        logic [DW/8-1:0] st;
        logic            v, l;
        d = '0;
        u = '0;
        st = '1;
        d[23:0] = {8'(s), 8'(pid[s]), 8'(beat[s])};
        d[DW-1 -: 8] = 8'hA5;
        u[23:0] = ~d[23:0];
        st = st >> beat[s];
        v = (pkt_left[s] > 0) && (lcyc >= start[s]);
        l = (beat[s] == plen[s] - 1);
        if (s == 0) begin
            s0_if.tdata = d; s0_if.tuser = u; s0_if.tstrb = st; s0_if.tvalid = v; s0_if.tlast = l;
        end else begin
            s1_if.tdata = d; s1_if.tuser = u; s1_if.tstrb = st; s1_if.tvalid = v; s1_if.tlast = l;
        end
    endtask

    task automatic sample();
        int s, b;
        logic [DW/8-1:0] st;
        hs[0] = s0_if.tvalid && s0_if.tready;
        hs[1] = s1_if.tvalid && s1_if.tready;
        if (s0_if.tready && s1_if.tready) overlap_bad++;
        if (!m_if.tvalid && (m_if.tdata !== '0 || m_if.tlast !== 1'b0 || m_if.tuser !== '0 || m_if.tstrb !== '0))
            idle_bad++;
        if (tog_chk && m_if.tvalid && (s1_if.tready !== m_if.tready || s0_if.tready !== 1'b0))
            mirror_bad++;
        if ((m_if.tvalid && m_if.tready) != (hs[0] || hs[1])) bad_fmt++;
        if (m_if.tvalid && m_if.tready) begin
            s = int'(m_if.tdata[23:16]);
            b = int'(m_if.tdata[7:0]);
            out_src.push_back(s);
            out_pid.push_back(int'(m_if.tdata[15:8]));
            out_beat.push_back(b);
            out_cyc.push_back(lcyc);
            if (b == 0) ord_src.push_back(s);
            st = '1;
            st = st >> b;
            if (s > 1) bad_fmt++;
            else if (m_if.tuser[23:0] !== ~m_if.tdata[23:0] || m_if.tstrb !== st ||
                     m_if.tlast !== (b == plen[s] - 1))
                bad_fmt++;
        end
    endtask

    task automatic advance();
        for (int s = 0; s < 2; s++) begin
            if (hs[s]) begin
                if (beat[s] == plen[s] - 1) begin
                    beat[s] = 0;
                    pid[s]++;
                    pkt_left[s]--;
                end else begin
                    beat[s]++;
                end
            end
            hs[s] = 1'b0;
        end
        lcyc++;
        if (tog_mode) m_if.tready = ~m_if.tready;
        drive_src(0);
        drive_src(1);
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic begin_test();
        out_src.delete(); out_pid.delete(); out_beat.delete(); out_cyc.delete(); ord_src.delete();
        lcyc = 0;
        hs[0] = 1'b0;
        hs[1] = 1'b0;
    endtask

    task automatic start_src(input int s, input int n, input int len, input int st);
        pkt_left[s] = n; plen[s] = len; beat[s] = 0; pid[s] = 0; start[s] = st;
    endtask

    task automatic run_pkts(input int max_cyc);
        int g = 0;
        drive_src(0);
        drive_src(1);
        while ((pkt_left[0] > 0 || pkt_left[1] > 0) && g < max_cyc) begin
            cycle();
            g++;
        end
        check_val("drain", 64'(pkt_left[0] + pkt_left[1]), 64'd0);
        cycle();
    endtask

    task automatic check_stream(input string tag);
        int np[2], nb[2], e, s;
        np[0] = 0; np[1] = 0; nb[0] = 0; nb[1] = 0; e = 0;
        for (int i = 0; i < out_src.size(); i++) begin
            s = out_src[i];
            if (s > 1) begin
                e++;
            end else begin
                if (out_pid[i] != np[s] || out_beat[i] != nb[s]) e++;
                if (nb[s] == plen[s] - 1) begin nb[s] = 0; np[s]++; end
                else nb[s]++;
            end
        end
        check_val(tag, 64'(e), 64'd0);
    endtask

    task automatic check_cnts(input string tag, input int c0, input int c1);
        check_val({tag, "_cnt0"}, 64'(pkt_cnt_0), STATS_EN ? 64'(c0) : 64'd0);
        check_val({tag, "_cnt1"}, 64'(pkt_cnt_1), STATS_EN ? 64'(c1) : 64'd0);
    endtask

    function automatic logic [63:0] order_vec();
        logic [63:0] v = '0;
        foreach (ord_src[i]) v = {v[62:0], ord_src[i][0]};
        return v;
    endfunction

    initial begin
        int g;
        tog_mode = 1'b0; tog_chk = 1'b0;
        for (int s = 0; s < 2; s++) start_src(s, 0, 1, 0);
        begin_test();
        rst = 1'b1;
        m_if.tready = 1'b0;
        drive_src(0);
        drive_src(1);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check_val("rst_rdy0", 64'(s0_if.tready), 64'd0);
        check_val("rst_rdy1", 64'(s1_if.tready), 64'd0);
        check_val("rst_tdata", m_if.tdata[63:0], 64'd0);
        check_cnts("rst", 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // s0 only: 3 packets x 4 beats
        begin_test();
        m_if.tready = 1'b1;
        start_src(0, 3, 4, 0);
        run_pkts(100);
        check_val("t1_beats", 64'(out_src.size()), 64'd12);
        check_stream("t1_stream");
        check_val("t1_span", (out_cyc.size() == 12) ? 64'(out_cyc[11] + 1) : 64'd0, 64'd15);
        check_val("t1_order", order_vec(), 64'b000);
        check_cnts("t1", 3, 0);

        // both saturated, 2-beat packets
        begin_test();
        start_src(0, 8, 2, 0);
        start_src(1, 2, 2, 0);
        run_pkts(200);
        check_val("t2_pkts", 64'(ord_src.size()), 64'd10);
        check_val("t2_order", order_vec(), 64'b0000100001);
        check_stream("t2_stream");
        check_cnts("t2", 11, 2);

        // s1 appears mid s0 packet
        begin_test();
        start_src(0, 1, 5, 0);
        start_src(1, 1, 3, 2);
        run_pkts(100);
        check_val("t3_beats", 64'(out_src.size()), 64'd8);
        check_val("t3_order", order_vec(), 64'b01);
        check_stream("t3_stream");
        check_val("t3_gap", (out_cyc.size() == 8) ? 64'(out_cyc[5] - out_cyc[4]) : 64'd0, 64'd2);
        check_cnts("t3", 12, 3);

        // back-pressure toggling on a 6-beat s1 packet
        begin_test();
        tog_mode = 1'b1; tog_chk = 1'b1;
        m_if.tready = 1'b1;
        start_src(1, 1, 6, 0);
        run_pkts(100);
        tog_mode = 1'b0; tog_chk = 1'b0;
        m_if.tready = 1'b1;
        check_val("t4_beats", 64'(out_src.size()), 64'd6);
        check_stream("t4_stream");
        check_val("t4_last_cyc", (out_cyc.size() == 6) ? 64'(out_cyc[5]) : 64'd0, 64'd12);
        check_val("t4_mirror", 64'(mirror_bad), 64'd0);
        check_cnts("t4", 12, 4);

        // reset during beat 3 of an s0 packet
        begin_test();
        start_src(0, 1, 6, 0);
        drive_src(0);
        drive_src(1);
        g = 0;
        while (beat[0] != 2 && g < 20) begin
            cycle();
            g++;
        end
        #2;
        check_val("t5_pre_valid", 64'(m_if.tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check_val("t5_rst_valid", 64'(m_if.tvalid), 64'd0);
        check_val("t5_rst_rdy0", 64'(s0_if.tready), 64'd0);
        check_val("t5_rst_rdy1", 64'(s1_if.tready), 64'd0);
        check_cnts("t5_rst", 0, 0);
        start_src(0, 0, 1, 0);
        drive_src(0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_idle_valid", 64'(m_if.tvalid), 64'd0);
        check_val("t5_idle_rdy0", 64'(s0_if.tready), 64'd0);
        @(posedge clk);
        #1;
        begin_test();
        start_src(1, 1, 2, 0);
        run_pkts(50);
        check_val("t5_beats", 64'(out_src.size()), 64'd2);
        check_stream("t5_stream");
        check_cnts("t5", 0, 1);

        check_val("fmt", 64'(bad_fmt), 64'd0);
        check_val("overlap", 64'(overlap_bad), 64'd0);
        check_val("idle_zero", 64'(idle_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_arbiter.md
# capture_arbiter

Packet-granular arbiter that merges the two copies produced by the packet duplicator onto one shared AXI-Stream master. Input 0 carries forwarded traffic and input 1 carries the captured duplicate. Forwarded traffic has strict priority; a burst limit guarantees the capture stream is never starved. The block sits directly downstream of the duplicator and upstream of the shared output queue or DMA port.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, data width of all streams
- C_M_AXIS_TUSER_WIDTH, 128, tuser width of all streams
- C_S_AXI_DATA_WIDTH, 32, width of the statistics counters
- MAX_S0_BURST, 4, consecutive input-0 packets allowed while input 1 waits (≥1)
- axi_aclk  in  1  single clock, all logic rising-edge
- axi_areset  in  1  asynchronous, active-high reset
- s_axis_tdata_0/1  in  C_M_AXIS_DATA_WIDTH  input data
- s_axis_tstrb_0/1  in  C_M_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser_0/1  in  C_M_AXIS_TUSER_WIDTH  sideband
- s_axis_tvalid_0/1  in  1  beat valid
- s_axis_tready_0/1  out  1  beat accepted
- s_axis_tlast_0/1  in  1  last beat of packet
- m_axis_tdata/tstrb/tuser/tlast  out  as above  muxed from the granted input
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- pkt_cnt_0, pkt_cnt_1  out  C_S_AXI_DATA_WIDTH  packets forwarded per input

## Operation
- States: IDLE, PKT0, PKT1. Reset state is IDLE.
- IDLE:
  - m_axis_tvalid=0; both s_axis_tready=0.
  - Arbitration, evaluated each cycle:
    - s1 valid and (no s0 valid, or burst_cnt==MAX_S0_BURST) → PKT1.
    - Otherwise s0 valid → PKT0.
    - Otherwise stay in IDLE.
- burst_cnt update, on leaving IDLE:
  - PKT0 grant with s1 valid → burst_cnt+1, saturating at MAX_S0_BURST.
  - PKT0 grant with s1 idle, or any PKT1 grant → burst_cnt=0.
- PKTn:
  - m_axis_* = s_axis_*_n, combinational.
  - s_axis_tready_n = m_axis_tready; the other input's tready=0.
  - Handshake of a beat with tlast=1 → IDLE.
- Grant never changes mid-packet, whatever the other input does.
- tuser passes through unmodified. Zero-length packets do not exist: every packet has at least one beat.
- pkt_cnt_n increments on each tlast handshake of input n and wraps modulo 2^C_S_AXI_DATA_WIDTH.

## Timing
- Reset (asynchronous, effective immediately):
  - state=IDLE, burst_cnt=0, pkt_cnt_0/1=0.
  - m_axis_tvalid=0; m_axis_tdata/tstrb/tuser/tlast=0, because IDLE forces the mux outputs to zero.
  - s_axis_tready_0/1=0.
- Reset mid-packet: the packet is truncated with no tlast emitted. Upstream and downstream are reset on the same signal.
- Latency from the first valid beat while in IDLE to m_axis_tvalid: 1 cycle.
- Inside a packet: 0 cycles, fully combinational data path with no buffering.
- One idle bubble is inserted after every packet's tlast beat.
- Back-pressure: m_axis_tready=0 holds the granted input stalled. Data and valid stay stable per the AXI-Stream rules because upstream keeps them stable.
- Simultaneous s0/s1 valid in IDLE resolves per the burst rule. With both inputs saturated, the steady-state ratio is MAX_S0_BURST:1.

## Configuration
- CAPTURE_ARB_STATS_EN defined: pkt_cnt_0/1 are live counters as described.
- Not defined: no counter registers are synthesised and pkt_cnt_0/1 are tied to 0. Arbitration is unaffected.

## Structure
- Package capture_arb_pkg holds:
  - the state enum (IDLE=0, PKT0=1, PKT1=2), 2 bits wide;
  - the burst counter width, $clog2(MAX_S0_BURST+1).
- One sub-module, capture_arb_stats: a dual packet counter, instantiated only under CAPTURE_ARB_STATS_EN.

## Test plan
- Only s0 sends 3 packets of 4 beats, m_axis_tready=1 → 15 output cycles (12 beats plus 3 bubbles), all data from s0, pkt_cnt_0=3, pkt_cnt_1=0.
- s0 and s1 both continuously valid with 2-beat packets, MAX_S0_BURST=4 → output packet order 0,0,0,0,1,0,0,0,0,1.
- s1 asserts valid during beat 2 of a 5-beat s0 packet → the s0 packet completes uninterrupted and s1 is granted after the bubble (s0 idle, so no burst check applies).
- m_axis_tready toggles 1/0 every cycle during a 6-beat s1 packet → all 6 beats arrive in order, s_axis_tready_1 mirrors m_axis_tready, s_axis_tready_0 stays 0.
- axi_areset pulsed high during beat 3 of a packet → same cycle: m_axis_tvalid=0 and both tready=0; after release, state=IDLE, counters=0, and the next packet is forwarded cleanly.
- Build without CAPTURE_ARB_STATS_EN, run 10 packets → pkt_cnt_0/1 read 0 throughout and the output stream is identical to the stats-enabled build.
